pt_lookup_engine: RTL and testbench

//   Parametrised page-table lookup engine serving TLB misses for speculative

---
 rtl/pt_pkg.sv | 24 ++
 rtl/pt_entry_array.sv | 55 +++++
 rtl/pt_lookup_engine.sv | 118 +++++++++++
 tb/tb_pt_lookup_engine.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pt_pkg.sv
// pt_pkg: shared FSM state type, entry layout and default widths for the page-table lookup engine.
`default_nettype none

package pt_pkg;

  localparam int DEF_VPN_W   = 4;
  localparam int DEF_PPN_W   = 4;
  localparam int DEF_ENTRIES = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [DEF_VPN_W-1:0] vpn;
    logic [DEF_PPN_W-1:0] ppn;
  } pt_entry_t;

endpackage

`default_nettype wire

// File: rtl/pt_entry_array.sv
// pt_entry_array: register-based {valid,vpn,ppn} storage with one write port,
// a global invalidate and an asynchronous read port.
`default_nettype none

module pt_entry_array
  import pt_pkg::*;
#(
  parameter int VPN_W   = DEF_VPN_W,
  parameter int PPN_W   = DEF_PPN_W,
  parameter int ENTRIES = DEF_ENTRIES,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_valid,
  input  logic [VPN_W-1:0] wr_vpn,
  input  logic [PPN_W-1:0] wr_ppn,
  input  logic             inv_all,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [VPN_W-1:0] rd_vpn,
  output logic [PPN_W-1:0] rd_ppn
);

  typedef struct packed {
    logic             valid;
    logic [VPN_W-1:0] vpn;
    logic [PPN_W-1:0] ppn;
  } entry_t;

  entry_t mem [ENTRIES];

  // The write is ordered after the invalidate so a same-cycle write survives it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) mem[i].valid <= 1'b0;
    end else begin
      if (inv_all) begin
        for (int i = 0; i < ENTRIES; i++) mem[i].valid <= 1'b0;
      end
      if (wr_en) begin
        mem[wr_idx] <= '{valid: wr_valid, vpn: wr_vpn, ppn: wr_ppn};
      end
    end
  end

  assign rd_valid = mem[rd_idx].valid;
  assign rd_vpn   = mem[rd_idx].vpn;
  assign rd_ppn   = mem[rd_idx].ppn;

endmodule

`default_nettype wire

// File: rtl/pt_lookup_engine.sv
// pt_lookup_engine: sequential page-table search, one entry per clock,
// returning a registered hit/miss response strobe.
`default_nettype none

module pt_lookup_engine
  import pt_pkg::*;
#(
  parameter int VPN_W   = DEF_VPN_W,
  parameter int PPN_W   = DEF_PPN_W,
  parameter int ENTRIES = DEF_ENTRIES,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lookup_req,
  input  logic [VPN_W-1:0] lookup_vpn,
  output logic             lookup_ready,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [VPN_W-1:0] resp_vpn,
  output logic [PPN_W-1:0] resp_ppn,
  output logic             busy,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_valid,
  input  logic [VPN_W-1:0] wr_vpn,
  input  logic [PPN_W-1:0] wr_ppn,
  input  logic             inv_all
);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [VPN_W-1:0] req_vpn;
  logic             rd_valid;
  logic [VPN_W-1:0] rd_vpn;
  logic [PPN_W-1:0] rd_ppn;
  logic             accept;
  logic             match;
  logic             last;

  pt_entry_array #(
    .VPN_W  (VPN_W),
    .PPN_W  (PPN_W),
    .ENTRIES(ENTRIES),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_valid(wr_valid),
    .wr_vpn  (wr_vpn),
    .wr_ppn  (wr_ppn),
    .inv_all (inv_all),
    .rd_idx  (idx),
    .rd_valid(rd_valid),
    .rd_vpn  (rd_vpn),
    .rd_ppn  (rd_ppn)
  );

  assign lookup_ready = (state == IDLE);
  assign busy         = (state != IDLE);
  assign accept       = lookup_req && lookup_ready;
  assign match        = rd_valid && (rd_vpn == req_vpn);
  assign last         = (idx == IDX_W'(ENTRIES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SEARCH;
      SEARCH:  if (match || last) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Response fields are loaded on the SEARCH->RESP transition and then held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx        <= '0;
      req_vpn    <= '0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_vpn   <= '0;
      resp_ppn   <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (accept) begin
        req_vpn <= lookup_vpn;
        idx     <= '0;
      end
      if (state == SEARCH) begin
        if (match) begin
          resp_valid <= 1'b1;
          resp_hit   <= 1'b1;
          resp_vpn   <= req_vpn;
          resp_ppn   <= rd_ppn;
        end else if (last) begin
          resp_valid <= 1'b1;
          resp_hit   <= 1'b0;
          resp_vpn   <= req_vpn;
          resp_ppn   <= '0;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pt_lookup_engine.sv
// tb_pt_lookup_engine: directed and randomized lookups checked against a
// table-level reference model (lowest matching valid index, latency index+1).
`default_nettype none

module tb_pt_lookup_engine;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lookup_req = 1'b0;
  logic [3:0] lookup_vpn = '0;
  logic       lookup_ready;
  logic       resp_valid;
  logic       resp_hit;
  logic [3:0] resp_vpn;
  logic [3:0] resp_ppn;
  logic       busy;
  logic       wr_en = 1'b0;
  logic [2:0] wr_idx = '0;
  logic       wr_valid = 1'b0;
  logic [3:0] wr_vpn = '0;
  logic [3:0] wr_ppn = '0;
  logic       inv_all = 1'b0;

  int checks = 0;
  int errors = 0;

  bit         ref_v   [N];
  logic [3:0] ref_vpn [N];
  logic [3:0] ref_ppn [N];

  always #5 clk = ~clk;

  pt_lookup_engine dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lookup_req  (lookup_req),
    .lookup_vpn  (lookup_vpn),
    .lookup_ready(lookup_ready),
    .resp_valid  (resp_valid),
    .resp_hit    (resp_hit),
    .resp_vpn    (resp_vpn),
    .resp_ppn    (resp_ppn),
    .busy        (busy),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_valid    (wr_valid),
    .wr_vpn      (wr_vpn),
    .wr_ppn      (wr_ppn),
    .inv_all     (inv_all)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int j = 0; j < N; j++) ref_v[j] = 1'b0;
  endtask

  task automatic write_entry(input int i, input bit v, input logic [3:0] tv, input logic [3:0] tp,
                             input bit inv);
    @(negedge clk);
    wr_en = 1'b1; wr_idx = 3'(i); wr_valid = v; wr_vpn = tv; wr_ppn = tp; inv_all = inv;
    @(negedge clk);
    wr_en = 1'b0; inv_all = 1'b0;
    if (inv) clear_model();
    ref_v[i] = v; ref_vpn[i] = tv; ref_ppn[i] = tp;
  endtask

  task automatic inv_pulse();
    @(negedge clk);
    inv_all = 1'b1;
    @(negedge clk);
    inv_all = 1'b0;
    clear_model();
  endtask

  task automatic predict(input logic [3:0] v, output bit hit, output logic [3:0] ppn, output int lat);
    hit = 1'b0; ppn = '0; lat = N;
    for (int k = N - 1; k >= 0; k--) begin
      if (ref_v[k] && ref_vpn[k] == v) begin
        hit = 1'b1; ppn = ref_ppn[k]; lat = k + 1;
      end
    end
  endtask

  // Issues one lookup; inv_cyc selects a search cycle (relative to accept) that pulses inv_all.
  task automatic lookup(input string tag, input logic [3:0] v, input int inv_cyc,
                        output bit hit, output logic [3:0] ppn, output int lat);
    int wait_c;
    bit got;
    wait_c = 0; got = 1'b0; hit = 1'b0; ppn = '0; lat = -1;
    @(negedge clk);
    lookup_req = 1'b1; lookup_vpn = v;
    while (!lookup_ready && wait_c < 50) begin
      @(negedge clk);
      wait_c++;
    end
    check({tag, "_ready"}, 32'(lookup_ready), 1);
    @(posedge clk);
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (c == 0) lookup_req = 1'b0;
      if (resp_valid) begin
        got = 1'b1; lat = c; hit = resp_hit; ppn = resp_ppn;
        check({tag, "_vpn"}, 32'(resp_vpn), 32'(v));
      end else begin
        check({tag, "_busy"}, 32'(busy), 1);
      end
      inv_all = (c == inv_cyc);
    end
    inv_all = 1'b0;
    check({tag, "_got"}, 32'(got), 1);
    @(negedge clk);
    check({tag, "_strobe_end"}, 32'(resp_valid), 0);
    check({tag, "_ready_back"}, 32'(lookup_ready), 1);
    check({tag, "_hold"}, {30'd0, resp_hit, 1'b0} | 32'(resp_ppn != ppn), {30'd0, hit, 1'b0});
  endtask

  task automatic run_and_check(input string tag, input logic [3:0] v);
    bit         eh, oh;
    logic [3:0] ep, op;
    int         el, ol;
    predict(v, eh, ep, el);
    lookup(tag, v, -1, oh, op, ol);
    check({tag, "_hit"}, 32'(oh), 32'(eh));
    check({tag, "_ppn"}, 32'(op), 32'(ep));
    check({tag, "_lat"}, 32'(ol), 32'(el));
  endtask

  initial begin
    bit         oh;
    logic [3:0] op;
    int         ol, cnt;
    logic [5:0] rv_seq, rdy_seq;

    clear_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_ready", 32'(lookup_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_rv", 32'(resp_valid), 0);
    check("rst_resp", {24'd0, resp_hit, resp_vpn, 3'd0} | 32'(resp_ppn), 0);

    write_entry(3, 1'b1, 4'hA, 4'h5, 1'b0);
    run_and_check("hit_idx3", 4'hA);

    inv_pulse();
    run_and_check("empty_miss", 4'h7);

    write_entry(1, 1'b1, 4'h2, 4'h9, 1'b0);
    write_entry(6, 1'b1, 4'h2, 4'h3, 1'b0);
    run_and_check("dup_low", 4'h2);

    // Back-to-back with req held: second accept when ready returns.
    write_entry(0, 1'b1, 4'h1, 4'h6, 1'b0);
    @(negedge clk);
    lookup_req = 1'b1; lookup_vpn = 4'h1;
    cnt = 0;
    while (!lookup_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    @(posedge clk);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      rv_seq[c]  = resp_valid;
      rdy_seq[c] = lookup_ready;
      if (c == 3) lookup_req = 1'b0;
    end
    check("b2b_rv_seq", 32'(rv_seq), 32'(6'b010010));
    check("b2b_rdy_seq", 32'(rdy_seq), 32'(6'b100100));
    check("b2b_ppn", 32'(resp_ppn), 32'h6);

    // Invalidate mid-search: entry at idx5 is gone before it is compared.
    write_entry(5, 1'b1, 4'hD, 4'hE, 1'b0);
    lookup("inv_mid", 4'hD, 1, oh, op, ol);
    clear_model();
    check("inv_mid_hit", 32'(oh), 0);
    check("inv_mid_ppn", 32'(op), 0);
    check("inv_mid_lat", 32'(ol), N);

    write_entry(4, 1'b1, 4'h4, 4'h1, 1'b0);
    write_entry(7, 1'b1, 4'hB, 4'hC, 1'b0);
    write_entry(2, 1'b1, 4'h4, 4'h8, 1'b1);
    run_and_check("invwr_keep", 4'h4);
    run_and_check("invwr_gone", 4'hB);

    // Reset in the middle of a lookup aborts without a response.
    write_entry(5, 1'b1, 4'hC, 4'h4, 1'b0);
    @(negedge clk);
    lookup_req = 1'b1; lookup_vpn = 4'hC;
    @(posedge clk);
    @(negedge clk);
    lookup_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_ready", 32'(lookup_ready), 1);
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_rv", 32'(resp_valid), 0);
    rst_n = 1'b1;
    clear_model();
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (resp_valid) cnt++;
    end
    check("rstmid_no_resp", 32'(cnt), 0);
    run_and_check("rstmid_cleared", 4'hC);

    for (int it = 0; it < 40; it++) begin
      logic [3:0] v;
      int nw;
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++) begin
        write_entry($urandom_range(0, N - 1), ($urandom_range(0, 3) != 0),
                    4'($urandom), 4'($urandom), ($urandom_range(0, 9) == 0));
      end
      if ($urandom_range(0, 1) == 1) v = ref_vpn[$urandom_range(0, N - 1)];
      else v = 4'($urandom);
      if ($isunknown(v)) v = 4'($urandom);
      run_and_check($sformatf("rand%0d", it), v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
